// File: rtl/beat_packer.sv
// Packs RATIO consecutive WIDTH-bit beats into one word. The word is presented on a
// registered valid/ready output together with its beat count. last_up closes a word early.
module beat_packer #(
  parameter int WIDTH = 4,
  parameter int RATIO = 4,
  localparam int CNTW = $clog2(RATIO) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_up,
  input  logic [WIDTH-1:0]       data_up,
  input  logic                   last_up,
  output logic                   ready_up,
  output logic                   valid_down,
  output logic [WIDTH*RATIO-1:0] data_down,
  output logic [CNTW-1:0]        count_down,
  input  logic                   ready_down
);

  localparam int IDXW = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(RATIO - 1);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t          state;
  logic [IDXW-1:0] idx;
  logic            beat_acc;
  logic            word_acc;

  // data_down doubles as the slot store, so slots not yet written in a word read 0.
  assign valid_down = (state == HOLD);
  assign ready_up   = rst & (!valid_down | ready_down);
  assign beat_acc   = valid_up & ready_up;
  assign word_acc   = valid_down & ready_down;

  // NOTE: all state here updates with non-blocking assignments. Every branch below
  // reads the values from before the clock edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      idx        <= '0;
      data_down  <= '0;
      count_down <= '0;
    end else if (word_acc) begin
      // The word drains. A beat taken in the same cycle opens the next word in slot 0.
      state      <= FILL;
      idx        <= '0;
      count_down <= '0;
      data_down  <= beat_acc ? (WIDTH*RATIO)'(data_up) : '0;
      if (beat_acc) begin
        if (last_up) begin
          state      <= HOLD;
          count_down <= CNTW'(1);
        end else begin
          idx <= IDXW'(1);
        end
      end
    end else if (beat_acc) begin
      data_down[idx*WIDTH +: WIDTH] <= data_up;
      if (idx == LAST_IDX || last_up) begin
        state      <= HOLD;
        count_down <= CNTW'(idx) + CNTW'(1);
        idx        <= '0;
      end else begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_beat_packer.sv
// Directed and randomised checks for beat_packer with WIDTH=4, RATIO=4.
// Expected words come from hand-computed constants and from a transaction-level scoreboard.
module tb_beat_packer;

  logic        clk;
  logic        rst;
  logic        valid_up;
  logic [3:0]  data_up;
  logic        last_up;
  logic        ready_up;
  logic        valid_down;
  logic [15:0] data_down;
  logic [2:0]  count_down;
  logic        ready_down;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
  } word_t;

  word_t exp_q[$];

  beat_packer #(.WIDTH(4), .RATIO(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_up   (valid_up),
    .data_up    (data_up),
    .last_up    (last_up),
    .ready_up   (ready_up),
    .valid_down (valid_down),
    .data_down  (data_down),
    .count_down (count_down),
    .ready_down (ready_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [15:0] d, input logic [2:0] c);
    check({tag, "_valid"}, valid_down, 1);
    check({tag, "_data"}, data_down, d);
    check({tag, "_count"}, count_down, c);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic l);
    valid_up = 1'b1;
    data_up  = d;
    last_up  = l;
    tick();
  endtask

  logic        s_beat, s_word, s_last;
  logic [3:0]  s_data;
  logic [15:0] s_wdata;
  logic [2:0]  s_wcnt;
  logic [15:0] cur_word;
  int          cur_cnt;
  int          nwords;
  word_t       w;

  initial begin
    rst        = 1'b0;
    valid_up   = 1'b1;
    data_up    = 4'h7;
    last_up    = 1'b0;
    ready_down = 1'b1;

    // Reset state, with a beat offered that must not be taken.
    #3;
    check("rst_valid", valid_down, 0);
    check("rst_data", data_down, 0);
    check("rst_count", count_down, 0);
    check("rst_ready_up", ready_up, 0);
    #9 rst = 1'b1;
    valid_up = 1'b0;
    tick();

    // Continuous stream of 1..8 with the consumer always ready.
    for (int k = 1; k <= 8; k++) begin
      valid_up = 1'b1;
      data_up  = k[3:0];
      last_up  = 1'b0;
      #1;
      check("t2_ready_up", ready_up, 1);
      tick();
      if (k % 4 == 0) check_word("t2_word", (k == 4) ? 16'h4321 : 16'h8765, 3'd4);
      else            check("t2_valid_low", valid_down, 0);
    end
    valid_up = 1'b0;
    tick();
    check("t2_drained", valid_down, 0);

    // Short word, then a single-beat word back to back.
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b1);
    check_word("t3_short", 16'h0321, 3'd3);
    send(4'h9, 1'b1);
    check_word("t3_single", 16'h0009, 3'd1);
    valid_up = 1'b0;
    tick();
    check("t3_drained", valid_down, 0);

    // Backpressure while a word is held.
    ready_down = 1'b0;
    for (int k = 1; k <= 4; k++) send(k[3:0], 1'b0);
    check_word("t4_held", 16'h4321, 3'd4);
    valid_up = 1'b1;
    data_up  = 4'h5;
    last_up  = 1'b0;
    #1;
    check("t4_ready_low", ready_up, 0);
    tick();
    tick();
    check_word("t4_stable", 16'h4321, 3'd4);
    ready_down = 1'b1;
    #1;
    check("t4_ready_release", ready_up, 1);
    tick();
    check("t4_drain_valid", valid_down, 0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    send(4'h8, 1'b0);
    check_word("t4_next", 16'h8765, 3'd4);
    valid_up = 1'b0;
    tick();

    // Reset in the middle of a word, then reset during HOLD.
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    valid_up = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t5_rst_valid", valid_down, 0);
    check("t5_rst_data", data_down, 0);
    check("t5_rst_count", count_down, 0);
    check("t5_rst_ready_up", ready_up, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    for (int k = 3; k <= 6; k++) send(k[3:0], 1'b0);
    check_word("t5_word", 16'h6543, 3'd4);
    valid_up   = 1'b0;
    ready_down = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("t5_hold_drop", valid_down, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    ready_down = 1'b1;
    tick();
    check("t5_no_ghost", valid_down, 0);

    // Random traffic against a scoreboard; the final cycles drain with no new beats.
    cur_word = '0;
    cur_cnt  = 0;
    nwords   = 0;
    for (int i = 0; i < 1010; i++) begin
      if (i < 1000) begin
        valid_up   = ($urandom_range(0, 9) < 7);
        data_up    = 4'($urandom);
        last_up    = ($urandom_range(0, 4) == 0);
        ready_down = 1'($urandom_range(0, 1));
      end else begin
        valid_up   = 1'b0;
        ready_down = 1'b1;
      end
      @(negedge clk);
      check("rnd_ready_up", ready_up, !valid_down || ready_down);
      s_beat  = valid_up && ready_up;
      s_word  = valid_down && ready_down;
      s_data  = data_up;
      s_last  = last_up;
      s_wdata = data_down;
      s_wcnt  = count_down;
      tick();
      if (s_word) begin
        check("rnd_word_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("rnd_data", s_wdata, w.d);
          check("rnd_count", s_wcnt, w.c);
          nwords++;
        end
      end
      if (s_beat) begin
        cur_word[cur_cnt*4 +: 4] = s_data;
        cur_cnt++;
        if (cur_cnt == 4 || s_last) begin
          w.d = cur_word;
          w.c = 3'(cur_cnt);
          exp_q.push_back(w);
          cur_word = '0;
          cur_cnt  = 0;
        end
      end
    end
    check("rnd_queue_empty", exp_q.size(), 0);
    check("rnd_activity", nwords > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
